shift_sequencer: RTL and testbench

Command-driven controller that sits directly upstream of the 4-bit universal shift register and drives its mode, enable, serial-in and parallel-in lines. It accepts one shift command (operation, operand, amount) over a valid/ready handshake and loads the operand into the register. It then issues one single-bit shift per cycle until the amount is exhausted, and returns the register output as the result over a second valid/ready handshake. The processor datapath uses it to perform multi-bit logical, arithmetic and rotate shifts with the existing single-step register.

---
 rtl/shift_sequencer_if.sv | 25 ++
 rtl/shift_sequencer.sv | 145 ++++++++++++++
 tb/tb_shift_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Command/result handshake bundle for shift_sequencer.
// master = requester side, slave = sequencer side.
interface shift_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [AMT_W-1:0] cmd_amt;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_amt, res_ready,
      input  cmd_ready, res_valid, res_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_amt, res_ready,
      output cmd_ready, res_valid, res_data
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit shift sequencer driving a single-step universal shift register.
// Define SHIFT_SEQ_ROTATE_EN to enable op 11 as rotate-right.
module shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   shift_sequencer_if.slave bus,
   output logic             sr_c1,
   output logic             sr_c0,
   output logic             sr_enb,
   output logic             sr_sli,
   output logic             sr_sri,
   output logic [WIDTH-1:0] sr_in,
   input  logic [WIDTH-1:0] sr_out
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [AMT_W:0] WIDTH_A = (AMT_W + 1)'(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_SHL = 2'b00,
      OP_SHR = 2'b01,
      OP_SAR = 2'b10,
      OP_ROR = 2'b11
   } op_t;

   state_t           state;
   op_t              op_q;
   op_t              op_eff;
   logic [WIDTH-1:0] data_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_eff;
   logic [AMT_W:0]   amt_x;
   logic             rdy_q;
   logic             vld_q;
   logic             enb_q;
   logic [1:0]       mode_q;

   assign amt_x = {1'b0, bus.cmd_amt};

   // Decode the incoming command into the op and count to be latched.
   always_comb begin
      op_eff = op_t'(bus.cmd_op);
      if (amt_x >= WIDTH_A) cnt_eff = CW'(WIDTH);
      else                  cnt_eff = CW'(amt_x);
`ifdef SHIFT_SEQ_ROTATE_EN
      if (op_eff == OP_ROR) cnt_eff = CW'(amt_x % WIDTH_A);
`else
      if (op_eff == OP_ROR) op_eff = OP_SHR;
`endif
   end

   // Sequencer FSM; control outputs are registered for the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= OP_SHL;
         data_q <= '0;
         cnt_q  <= '0;
         rdy_q  <= 1'b1;
         vld_q  <= 1'b0;
         enb_q  <= 1'b0;
         mode_q <= 2'b00;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  op_q   <= op_eff;
                  data_q <= bus.cmd_data;
                  cnt_q  <= cnt_eff;
                  state  <= LOAD;
                  rdy_q  <= 1'b0;
                  enb_q  <= 1'b1;
                  mode_q <= 2'b11;
               end
            end
            LOAD: begin
               if (cnt_q != '0) begin
                  state  <= SHIFT;
                  mode_q <= (op_q == OP_SHL) ? 2'b10 : 2'b01;
               end else begin
                  state  <= DONE;
                  enb_q  <= 1'b0;
                  mode_q <= 2'b00;
                  vld_q  <= 1'b1;
               end
            end
            SHIFT: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state  <= DONE;
                  enb_q  <= 1'b0;
                  mode_q <= 2'b00;
                  vld_q  <= 1'b1;
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  state <= IDLE;
                  vld_q <= 1'b0;
                  rdy_q <= 1'b1;
               end
            end
         endcase
      end
   end

   // Control outputs are forced quiet while reset is held.
   assign bus.cmd_ready = rdy_q & ~rst;
   assign bus.res_valid = vld_q & ~rst;
   assign bus.res_data  = sr_out;
   assign sr_enb        = enb_q & ~rst;
   assign sr_c1         = mode_q[1] & ~rst;
   assign sr_c0         = mode_q[0] & ~rst;
   assign sr_sli        = 1'b0;

   // Parallel input and right-shift fill bit selection.
   always_comb begin
      sr_in  = '0;
      sr_sri = 1'b0;
      if (!rst) begin
         case (state)
            LOAD: sr_in = data_q;
            SHIFT: begin
               sr_in = sr_out;
               if (op_q == OP_SAR) sr_sri = sr_out[WIDTH-1];
`ifdef SHIFT_SEQ_ROTATE_EN
               if (op_q == OP_ROR) sr_sri = sr_out[0];
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer with a behavioural shift register model.
// Directed table, hand sequences and randomized commands vs a reference.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sr_c1, sr_c0, sr_enb, sr_sli, sr_sri;
   logic [3:0] sr_in;
   logic [3:0] sr_out;
   logic [3:0] reg_q = 4'b0000;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_sequencer_if #(.WIDTH(4), .AMT_W(3)) bus ();

   shift_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .sr_c1  (sr_c1),
      .sr_c0  (sr_c0),
      .sr_enb (sr_enb),
      .sr_sli (sr_sli),
      .sr_sri (sr_sri),
      .sr_in  (sr_in),
      .sr_out (sr_out)
   );

   assign sr_out = reg_q;

   // Universal shift register being controlled
   always_ff @(posedge clk) begin
      if (sr_enb) begin
         case ({sr_c1, sr_c0})
            2'b01: reg_q <= {sr_sri, reg_q[3:1]};
            2'b10: reg_q <= {reg_q[2:0], sr_sli};
            2'b11: reg_q <= sr_in;
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_cnt(input int op, input int amt);
`ifdef SHIFT_SEQ_ROTATE_EN
      if (op == 3) return amt % 4;
`endif
      return (amt > 4) ? 4 : amt;
   endfunction

   function automatic int ref_res(input int op, input int d, input int amt);
      int n;
      int s;
      int eop;
      int r;
      n = ref_cnt(op, amt);
      eop = op;
`ifndef SHIFT_SEQ_ROTATE_EN
      if (op == 3) eop = 1;
`endif
      case (eop)
         0: r = (d << n) & 15;
         1: r = d >> n;
         2: begin
            s = (d >= 8) ? d - 16 : d;
            r = (s >>> n) & 15;
         end
         default: r = ((d >> n) | (d << (4 - n))) & 15;
      endcase
      return r;
   endfunction

   task automatic run_cmd(input string name, input logic [1:0] op,
                          input logic [3:0] d, input logic [2:0] amt,
                          input int exp_res, input int exp_lat,
                          input int stall);
      int n;
      logic [3:0] held;
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         tick();
         n++;
      end
      if (!bus.cmd_ready) begin
         chk({name, " ready_timeout"}, 0, 1);
         return;
      end
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_amt   = amt;
      bus.cmd_valid = 1'b1;
      bus.res_ready = (stall == 0);
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 4'($urandom);
      bus.cmd_amt   = 3'($urandom);
      n = 1;
      while (!bus.res_valid && n < 30) begin
         tick();
         n++;
      end
      chk({name, " latency"}, n, exp_lat);
      chk({name, " res_data"}, bus.res_data, exp_res);
      if (stall > 0) begin
         held = bus.res_data;
         for (int i = 0; i < stall; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'($urandom);
            bus.cmd_data  = 4'($urandom);
            tick();
            chk({name, " hold_valid"}, bus.res_valid, 1);
            chk({name, " hold_data"}, bus.res_data, held);
            chk({name, " hold_nready"}, bus.cmd_ready, 0);
         end
         bus.cmd_valid = 1'b0;
         bus.res_ready = 1'b1;
      end
      tick();
      chk({name, " idle_ready"}, bus.cmd_ready, 1);
      chk({name, " idle_nvalid"}, bus.res_valid, 0);
      if (stall > 0) begin
         tick();
         chk({name, " no_accept"}, bus.cmd_ready, 1);
         chk({name, " no_enb"}, sr_enb, 0);
      end
   endtask

   typedef struct {
      logic [1:0] op;
      logic [3:0] d;
      logic [2:0] amt;
      logic [3:0] res;
      int         lat;
      int         stall;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int n;
      int hits;
      int op;
      int d;
      int amt;
      int st;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = 4'b0000;
      bus.cmd_amt   = 3'd0;
      bus.res_ready = 1'b1;

      tbl[0]  = '{2'd0, 4'b1010, 3'd1, 4'b0100, 3, 0};
      tbl[1]  = '{2'd2, 4'b1010, 3'd2, 4'b1110, 4, 0};
      tbl[2]  = '{2'd1, 4'b1010, 3'd2, 4'b0010, 4, 0};
      tbl[3]  = '{2'd3, 4'b1010, 3'd1, 4'b0101, 3, 0};
`ifdef SHIFT_SEQ_ROTATE_EN
      tbl[4]  = '{2'd3, 4'b1010, 3'd5, 4'b0101, 3, 0};
      tbl[9]  = '{2'd3, 4'b1010, 3'd4, 4'b1010, 2, 0};
`else
      tbl[4]  = '{2'd3, 4'b1010, 3'd5, 4'b0000, 6, 0};
      tbl[9]  = '{2'd3, 4'b1010, 3'd4, 4'b0000, 6, 0};
`endif
      tbl[5]  = '{2'd0, 4'b1010, 3'd0, 4'b1010, 2, 0};
      tbl[6]  = '{2'd1, 4'b1010, 3'd7, 4'b0000, 6, 0};
      tbl[7]  = '{2'd2, 4'b1010, 3'd7, 4'b1111, 6, 0};
      tbl[8]  = '{2'd0, 4'b0011, 3'd4, 4'b0000, 6, 0};
      tbl[10] = '{2'd2, 4'b0110, 3'd1, 4'b0011, 3, 0};
      tbl[11] = '{2'd2, 4'b1010, 3'd2, 4'b1110, 4, 5};

      // reset state
      tick();
      tick();
      chk("rst cmd_ready", bus.cmd_ready, 0);
      chk("rst res_valid", bus.res_valid, 0);
      chk("rst sr_enb", sr_enb, 0);
      chk("rst mode", {sr_c1, sr_c0}, 0);
      chk("rst fill", {sr_sli, sr_sri}, 0);
      chk("rst sr_in", sr_in, 0);
      rst = 1'b0;
      #1;
      chk("post_rst ready", bus.cmd_ready, 1);

      // mode sequence for SHL 1010 amt 1
      bus.cmd_op    = 2'd0;
      bus.cmd_data  = 4'b1010;
      bus.cmd_amt   = 3'd1;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      chk("seq load mode", {sr_c1, sr_c0}, 2'b11);
      chk("seq load enb", sr_enb, 1);
      chk("seq load sr_in", sr_in, 4'b1010);
      chk("seq load nready", bus.cmd_ready, 0);
      tick();
      chk("seq shift mode", {sr_c1, sr_c0}, 2'b10);
      chk("seq shift sr_in", sr_in, 4'b1010);
      chk("seq shift valid", bus.res_valid, 0);
      tick();
      chk("seq done mode", {sr_c1, sr_c0}, 2'b00);
      chk("seq done enb", sr_enb, 0);
      chk("seq done valid", bus.res_valid, 1);
      chk("seq done data", bus.res_data, 4'b0100);
      tick();
      chk("seq idle ready", bus.cmd_ready, 1);

      // directed table
      for (int i = 0; i < 12; i++) begin
         run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].d, tbl[i].amt,
                 int'(tbl[i].res), tbl[i].lat, tbl[i].stall);
      end

      // reset during second SHIFT cycle of SHL amt 3
      bus.cmd_op    = 2'd0;
      bus.cmd_data  = 4'b0001;
      bus.cmd_amt   = 3'd3;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      chk("abort pre enb", sr_enb, 1);
      rst = 1'b1;
      #1;
      chk("abort rst enb", sr_enb, 0);
      chk("abort rst ready", bus.cmd_ready, 0);
      chk("abort rst mode", {sr_c1, sr_c0}, 0);
      chk("abort rst sr_in", sr_in, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort idle ready", bus.cmd_ready, 1);
      chk("abort idle enb", sr_enb, 0);
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.res_valid) hits++;
      end
      chk("abort no result", hits, 0);
      run_cmd("after_abort", 2'd1, 4'b1100, 3'd2, 4'b0011, 4, 0);

      // randomized commands
      for (int i = 0; i < 150; i++) begin
         op  = int'($urandom_range(0, 3));
         d   = int'($urandom_range(0, 15));
         amt = int'($urandom_range(0, 7));
         st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         n   = ref_cnt(op, amt);
         run_cmd($sformatf("rnd%0d op%0d d%0h a%0d", i, op, d, amt),
                 2'(op), 4'(d), 3'(amt), ref_res(op, d, amt), n + 2, st);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
